// File: rtl/botassium_mem_arbiter_if.sv
// Requester-side and s2 memory-port signal bundle for the botassium memory arbiter.
// The arbiter takes the slave modport. Requesters and the memory take the master modport.
interface botassium_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          we;
  logic [NUM_REQ*ADDR_W-1:0]   addr;
  logic [NUM_REQ*DATA_W-1:0]   wdata;
  logic [NUM_REQ*DATA_W/8-1:0] be;
  logic [NUM_REQ-1:0]          ack;
  logic [NUM_REQ-1:0]          rvalid;
  logic [DATA_W-1:0]           rdata;
  logic [ADDR_W-1:0]           mem_address;
  logic                        mem_chipselect;
  logic                        mem_clken;
  logic                        mem_write;
  logic [DATA_W-1:0]           mem_writedata;
  logic [DATA_W/8-1:0]         mem_byteenable;
  logic [DATA_W-1:0]           mem_readdata;

  modport master (
    output req, we, addr, wdata, be, mem_readdata,
    input  ack, rvalid, rdata, mem_address, mem_chipselect, mem_clken,
           mem_write, mem_writedata, mem_byteenable
  );

  modport slave (
    input  req, we, addr, wdata, be, mem_readdata,
    output ack, rvalid, rdata, mem_address, mem_chipselect, mem_clken,
           mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/botassium_mem_arbiter.sv
// Round-robin arbiter sharing the Nios on-chip memory s2 port between NUM_REQ requesters.
// Read returns are routed back to their owner by a two-stage owner pipeline.
module botassium_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32
) (
  input logic                    clk_clk,
  input logic                    reset_reset_n,
  botassium_mem_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_stage1_owner;
  logic [NUM_REQ-1:0] r_stage2_owner;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata;
  logic [ADDR_W-1:0]  r_mem_address;
  logic               r_mem_chipselect;
  logic               r_mem_clken;
  logic               r_mem_write;
  logic [DATA_W-1:0]  r_mem_writedata;
  logic [BE_W-1:0]    r_mem_byteenable;

  logic               w_grant;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0] w_ack;
  logic [NUM_REQ-1:0] w_rd_owner;

  // Rotating-priority search: first set req at or after r_ptr, wrapping at NUM_REQ-1
  always_comb begin
    logic [PTR_W:0]   v_sum;
    logic [PTR_W:0]   v_mod;
    logic [PTR_W-1:0] v_idx;
    w_grant  = 1'b0;
    w_winner = '0;
    v_sum    = '0;
    v_mod    = '0;
    v_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum    = {1'b0, r_ptr} + (PTR_W+1)'(k);
      v_mod    = (v_sum >= NUM_REQ_W) ? (v_sum - NUM_REQ_W) : v_sum;
      v_idx    = v_mod[PTR_W-1:0];
      w_winner = (!w_grant && bus.req[v_idx]) ? v_idx : w_winner;
      w_grant  = w_grant | bus.req[v_idx];
    end
  end

  // One-hot grant (suppressed in reset), read-owner tag and next pointer
  always_comb begin
    w_ack      = '0;
    w_rd_owner = '0;
    w_ptr_next = (w_winner == LAST_REQ) ? '0 : (w_winner + PTR_W'(1));
    if (w_grant && reset_reset_n) begin
      w_ack[w_winner] = 1'b1;
    end else begin
      w_ack = '0;
    end
    w_rd_owner = bus.we[w_winner] ? '0 : w_ack;
  end

  // Issue stage, owner pipeline and read-return stage; no stall path exists
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_ptr            <= '0;
      r_stage1_owner   <= '0;
      r_stage2_owner   <= '0;
      r_rvalid         <= '0;
      r_rdata          <= '0;
      r_mem_address    <= '0;
      r_mem_chipselect <= 1'b0;
      r_mem_clken      <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_writedata  <= '0;
      r_mem_byteenable <= '0;
    end else begin
      r_mem_clken      <= 1'b1;
      r_mem_chipselect <= w_grant;
      r_mem_write      <= w_grant & bus.we[w_winner];
      if (w_grant) begin
        r_ptr            <= w_ptr_next;
        r_mem_address    <= bus.addr[int'(w_winner)*ADDR_W +: ADDR_W];
        r_mem_writedata  <= bus.wdata[int'(w_winner)*DATA_W +: DATA_W];
        r_mem_byteenable <= bus.be[int'(w_winner)*BE_W +: BE_W];
      end
      r_stage1_owner <= w_rd_owner;
      r_stage2_owner <= r_stage1_owner;
      r_rvalid       <= r_stage2_owner;
      r_rdata        <= bus.mem_readdata;
    end
  end

  assign bus.ack            = w_ack;
  assign bus.rvalid         = r_rvalid;
  assign bus.rdata          = r_rdata;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_chipselect = r_mem_chipselect;
  assign bus.mem_clken      = r_mem_clken;
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_writedata  = r_mem_writedata;
  assign bus.mem_byteenable = r_mem_byteenable;
endmodule

// File: doc/botassium_mem_arbiter.md
Name: botassium_mem_arbiter

Overview:
- Round-robin arbiter that shares the Nios on-chip memory fabric port (s2: 7-bit word address, 32-bit data, byte enables) between NUM_REQ fabric requesters, e.g. motor, sensor and logging blocks.
- Accepts one access per cycle, drives registered memory-port signals, and routes each read return to its owner through an owner-tracking pipeline.
- Sits between the fabric requesters and the s2 port of the botassium system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, memory word-address width
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester access request; held with fields stable until ack
we  in  NUM_REQ  per-requester write (1) / read (0)
addr  in  NUM_REQ*ADDR_W  packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  packed write data
be  in  NUM_REQ*DATA_W/8  packed byte enables
ack  out  NUM_REQ  combinational one-hot grant; request accepted at this clock edge
rvalid  out  NUM_REQ  registered one-hot read-return strobe
rdata  out  DATA_W  registered read data, shared by all requesters, qualified by rvalid
mem_address  out  ADDR_W  to nios_mem_s2_address
mem_chipselect  out  1  to nios_mem_s2_chipselect
mem_clken  out  1  to nios_mem_s2_clken
mem_write  out  1  to nios_mem_s2_write
mem_writedata  out  DATA_W  to nios_mem_s2_writedata
mem_byteenable  out  DATA_W/8  to nios_mem_s2_byteenable
mem_readdata  in  DATA_W  from nios_mem_s2_readdata; valid one cycle after address is presented

Behaviour:
- Clocking: one clock, clk_clk. Reset is synchronous, active-low, on reset_reset_n.
- Reset values:
  - mem_* outputs 0, including mem_clken.
  - rvalid 0, rdata 0.
  - Round-robin pointer 0.
  - Owner pipeline cleared.
- After reset, mem_clken is 1 constantly.
- Arbitration (combinational, cycle C):
  - Search req starting at pointer, ascending with wrap from NUM_REQ-1 to 0.
  - The first set bit wins, and ack[winner]=1 in C.
  - ack is 0 while reset_reset_n=0.
  - ack is 0 when no req is set.
- Pointer update: on an edge with a grant, pointer <= winner+1 (mod NUM_REQ). With no grant it holds. A continuously requesting requester therefore waits at most NUM_REQ-1 grants.
- Issue stage (edge ending C):
  - mem_chipselect <= grant.
  - mem_write <= grant & we[winner].
  - mem_address, mem_writedata and mem_byteenable <= the winner's fields.
  - stage1_owner <= one-hot winner if the grant is a read, else 0.
  - With no grant, chipselect and write go to 0; address and data hold.
- Memory: samples the stage-1 signals at the edge ending C+1. mem_readdata is valid in C+2.
- Return stage (edge ending C+2): rdata <= mem_readdata and rvalid <= stage2_owner, where stage2_owner <= stage1_owner at the edge ending C+1.
- Latency:
  - Read: ack in C, rvalid/rdata in C+3, one-cycle pulse.
  - Write: committed to memory at the edge ending C+1; no return strobe.
- Throughput: one access per cycle. Back-to-back reads from any mix of requesters return in grant order, one per cycle. There is no stall path, because the memory port never back-pressures.
- Requester rules:
  - Fields are sampled only at the ack edge.
  - Dropping req before ack withdraws the request cleanly.
  - Re-requesting in the cycle after ack is legal and is arbitrated normally.
- Read-after-write: a write granted in C followed by a read of the same address granted in C+1 returns the new data. Memory write at the C+1 edge precedes the read sample at the C+2 edge.
- Reset mid-operation: in-flight reads are discarded. rvalid stays 0 until new reads complete, and no stale return is emitted after reset release.
- Writes with be=0 still occupy a slot and assert chipselect with mem_write=1 and byteenable 0.

Test Plan:
- Single read: memory word 5 = 0xDEADBEEF; req[1] read addr 5 in C -> ack[1] in C; mem_address=5, chipselect=1, write=0 in C+1; rvalid=4'b0010 and rdata=0xDEADBEEF in C+3 only.
- Round-robin fairness: all four req held high, reads, for 8 cycles after reset -> ack order 0,1,2,3,0,1,2,3; rvalid order identical, lagging 3 cycles; no cycle with two ack bits.
- Write then read: req[2] writes addr 0x7F, data 0x12345678, be=4'b0011, over old 0xAAAAAAAA; next cycle req[3] reads 0x7F -> rvalid[3] with rdata=0xAAAA5678.
- Idle and pointer hold: req[2] granted, then 5 idle cycles, then req[0] and req[3] together -> ack[3] first (pointer=3), then ack[0]; chipselect 0 throughout the idle cycles.
- Reset mid-flight: reads granted in C and C+1, reset_reset_n=0 in C+2 for one cycle -> rvalid 0 in C+2..C+5, mem_chipselect 0 and pointer back to 0 after release.
- Withdrawn request: req[1] raised while req[0] wins, then dropped before its turn -> ack[1] never asserted; no memory access for requester 1.
